// File: rtl/cnn_concat_upsampled_lowlevel_pkg.sv
// Shared parameters and types for the decoder concatenation stage.
// Defaults match the post-upsample 256x256 decoder geometry.
package cnn_concat_upsampled_lowlevel_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_IMAGE_WIDTH  = 256;
    localparam int DEF_IMAGE_HEIGHT = 256;
    localparam int DEF_CH_A         = 7;
    localparam int DEF_CH_B         = 3;

    localparam int DEF_IMAGE_SIZE = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
    localparam int DEF_A_TOTAL    = DEF_CH_A * DEF_IMAGE_SIZE;
    localparam int DEF_B_TOTAL    = DEF_CH_B * DEF_IMAGE_SIZE;
    localparam int DEF_B_ADDR_W   = $clog2(DEF_B_TOTAL + 1);

    typedef enum logic {
        PASS_A  = 1'b0,
        DRAIN_B = 1'b1
    } concat_state_t;

    // Width of a counter that must reach 'total' without wrapping.
    function automatic int cnt_width(input int total);
        return (total < 1) ? 1 : $clog2(total + 1);
    endfunction

endpackage

// File: rtl/cnn_concat_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Read data holds its value on cycles without a read.
module cnn_concat_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cnn_concat_upsampled_lowlevel.sv
// Concatenates stream A (passed through, latency 1) with stream B (buffered in RAM,
// replayed after the last A pixel of the frame). No backpressure; excess input is dropped.
module cnn_concat_upsampled_lowlevel
    import cnn_concat_upsampled_lowlevel_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int CH_A         = DEF_CH_A,
    parameter int CH_B         = DEF_CH_B
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_a,
    input  logic [DATA_WIDTH-1:0] pxl_a,
    input  logic                  valid_b,
    input  logic [DATA_WIDTH-1:0] pxl_b,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  err_overflow
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int A_TOTAL    = CH_A * IMAGE_SIZE;
    localparam int B_TOTAL    = CH_B * IMAGE_SIZE;
    localparam int A_CNT_W    = cnt_width(A_TOTAL);
    localparam int B_ADDR_W   = $clog2(B_TOTAL + 1);
    localparam int RAM_AW     = (B_TOTAL > 1) ? $clog2(B_TOTAL) : 1;

    localparam logic [A_CNT_W-1:0]  A_LAST = A_CNT_W'(A_TOTAL - 1);
    localparam logic [B_ADDR_W-1:0] B_FULL = B_ADDR_W'(B_TOTAL);
    localparam logic [B_ADDR_W-1:0] B_LAST = B_ADDR_W'(B_TOTAL - 1);

    concat_state_t state_q, state_d;

    logic [A_CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [B_ADDR_W-1:0]   wr_b_q, wr_b_d;
    logic [B_ADDR_W-1:0]   rd_b_q, rd_b_d;

    logic                  a_accept, a_drop, b_write, b_drop, rd_en, last_rd;
    logic [RAM_AW-1:0]     ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    logic [DATA_WIDTH-1:0] pxl_a_q;
    logic                  src_b_q;
    logic                  valid_out_q;
    logic                  frame_done_q;
    logic                  err_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PASS_A;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS_A:  if (a_accept && (cnt_a_q == A_LAST)) state_d = DRAIN_B;
            DRAIN_B: if (last_rd) state_d = PASS_A;
            default: state_d = PASS_A;
        endcase
    end

    // FSM: outputs (control strobes). On the last read the counters clear, and a
    // coincident valid_b belongs to the next frame, so it is written at address 0.
    always_comb begin
        a_accept    = (state_q == PASS_A) && valid_a;
        a_drop      = (state_q == DRAIN_B) && valid_a;
        rd_en       = (state_q == DRAIN_B) && (rd_b_q < wr_b_q);
        last_rd     = rd_en && (rd_b_q == B_LAST);
        b_write     = valid_b && ((wr_b_q < B_FULL) || last_rd);
        b_drop      = valid_b && !b_write;
        ram_wr_addr = last_rd ? '0 : wr_b_q[RAM_AW-1:0];
    end

    always_comb begin
        cnt_a_d = cnt_a_q;
        rd_b_d  = rd_b_q;
        wr_b_d  = wr_b_q;
        if (last_rd) begin
            cnt_a_d = '0;
            rd_b_d  = '0;
            wr_b_d  = b_write ? B_ADDR_W'(1) : '0;
        end else begin
            if (a_accept) cnt_a_d = cnt_a_q + A_CNT_W'(1);
            if (rd_en)    rd_b_d  = rd_b_q + B_ADDR_W'(1);
            if (b_write)  wr_b_d  = wr_b_q + B_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a_q      <= '0;
            wr_b_q       <= '0;
            rd_b_q       <= '0;
            pxl_a_q      <= '0;
            src_b_q      <= 1'b0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_a_q      <= cnt_a_d;
            wr_b_q       <= wr_b_d;
            rd_b_q       <= rd_b_d;
            valid_out_q  <= a_accept || rd_en;
            frame_done_q <= last_rd;
            err_q        <= err_q || a_drop || b_drop;
            if (a_accept) begin
                pxl_a_q <= pxl_a;
                src_b_q <= 1'b0;
            end else if (rd_en) begin
                src_b_q <= 1'b1;
            end
        end
    end

    cnn_concat_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (B_TOTAL),
        .ADDR_W     (RAM_AW)
    ) u_b_ram (
        .clk     (clk),
        .wr_en   (b_write),
        .wr_addr (ram_wr_addr),
        .wr_data (pxl_b),
        .rd_en   (rd_en),
        .rd_addr (rd_b_q[RAM_AW-1:0]),
        .rd_data (ram_rd_data)
    );

    // Both sources are registers that hold between transfers, so the mux output
    // keeps its last value on idle cycles.
    assign pxl_out      = src_b_q ? ram_rd_data : pxl_a_q;
    assign valid_out    = valid_out_q;
    assign frame_done   = frame_done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_cnn_concat_upsampled_lowlevel.sv
// Scoreboard bench for the concatenation stage (W=2, H=2, CH_A=2, CH_B=1).
// Expected words are queued as stimulus is driven and popped as outputs appear.
module tb_cnn_concat_upsampled_lowlevel;

    localparam int DW      = 32;
    localparam int A_TOTAL = 8;
    localparam int B_TOTAL = 4;
    localparam int FRAME   = A_TOTAL + B_TOTAL;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_a = 1'b0;
    logic [DW-1:0] pxl_a = '0;
    logic          valid_b = 1'b0;
    logic [DW-1:0] pxl_b = '0;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          frame_done;
    logic          err_overflow;

    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic          rst_q = 1'b1;
    int            out_idx = 0;
    int            fd_cnt = 0;
    int            last_a_cyc = 0;
    int            first_b_cyc = 0;
    int            last_b_cyc = 0;
    exp_t          exp_a[$];
    logic [DW-1:0] exp_b[$];

    cnn_concat_upsampled_lowlevel #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (2),
        .IMAGE_HEIGHT (2),
        .CH_A         (2),
        .CH_B         (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_a      (valid_a),
        .pxl_a        (pxl_a),
        .valid_b      (valid_b),
        .pxl_b        (pxl_b),
        .pxl_out      (pxl_out),
        .valid_out    (valid_out),
        .frame_done   (frame_done),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard: A words occupy output slots 0..7 of a frame, B words 8..11.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
            chk("rst_pxl_out", {32'd0, pxl_out}, 64'd0);
            chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
            chk("rst_err", {63'd0, err_overflow}, 64'd0);
            out_idx = 0;
        end else if (valid_out) begin
            if (out_idx < A_TOTAL) begin
                chk("a_avail", 64'(exp_a.size() > 0), 64'd1);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    chk("a_data", {32'd0, pxl_out}, {32'd0, e.data});
                    chk("a_latency", 64'(cyc), 64'(e.cyc));
                end
                chk("a_frame_done", {63'd0, frame_done}, 64'd0);
                if (out_idx == A_TOTAL - 1) last_a_cyc = cyc;
            end else begin
                chk("b_avail", 64'(exp_b.size() > 0), 64'd1);
                if (exp_b.size() > 0) begin
                    chk("b_data", {32'd0, pxl_out}, {32'd0, exp_b.pop_front()});
                end
                chk("b_frame_done", {63'd0, frame_done}, 64'(out_idx == FRAME - 1));
                if (out_idx == A_TOTAL) first_b_cyc = cyc;
                if (out_idx == FRAME - 1) last_b_cyc = cyc;
            end
            if (frame_done) fd_cnt++;
            $display("OUT cyc=%0d slot=%0d pxl=%08h frame_done=%0b err=%0b",
                     cyc, out_idx, pxl_out, frame_done, err_overflow);
            out_idx = (out_idx == FRAME - 1) ? 0 : out_idx + 1;
        end else if (frame_done) begin
            chk("frame_done_without_valid", {63'd0, frame_done}, 64'd0);
        end
    end

    // One input cycle; ea/eb say whether the word is expected to reach the output.
    task automatic drive(input logic va, input logic [DW-1:0] a, input logic vb,
                         input logic [DW-1:0] b, input logic ea, input logic eb);
        valid_a = va;
        pxl_a   = a;
        valid_b = vb;
        pxl_b   = b;
        if (ea) exp_a.push_back('{a, cyc + 1});
        if (eb) exp_b.push_back(b);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_a(input logic [DW-1:0] base);
        for (int i = 0; i < A_TOTAL; i++) drive(1'b1, base + DW'(i), 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic send_b(input logic [DW-1:0] base);
        for (int i = 0; i < B_TOTAL; i++) drive(1'b0, '0, 1'b1, base + DW'(i), 1'b0, 1'b1);
    endtask

    task automatic end_test(input string name);
        idle(10);
        chk({name, "_a_drained"}, 64'(exp_a.size()), 64'd0);
        chk({name, "_b_drained"}, 64'(exp_b.size()), 64'd0);
        chk({name, "_frame_aligned"}, 64'(out_idx), 64'd0);
    endtask

    initial begin
        int fd0;

        do_reset();

        // A then B, each back-to-back
        fd0 = fd_cnt;
        send_a(32'h10);
        send_b(32'h20);
        end_test("t1");
        chk("t1_b_contiguous", 64'(last_b_cyc - first_b_cyc), 64'd3);
        chk("t1_frame_done_count", 64'(fd_cnt - fd0), 64'd1);
        chk("t1_err", {63'd0, err_overflow}, 64'd0);

        // B first, then A: B must follow the last A word with no gap
        send_b(32'h20);
        send_a(32'h10);
        end_test("t2");
        chk("t2_no_gap", 64'(first_b_cyc - last_a_cyc), 64'd1);
        chk("t2_err", {63'd0, err_overflow}, 64'd0);

        // Interleaved, B finishing after A
        for (int i = 0; i < A_TOTAL; i++) begin
            drive(1'b1, 32'h10 + DW'(i), 1'b0, '0, 1'b1, 1'b0);
            if (i >= A_TOTAL - B_TOTAL)
                drive(1'b0, '0, 1'b1, 32'h20 + DW'(i - (A_TOTAL - B_TOTAL)), 1'b0, 1'b1);
            else
                idle(1);
        end
        end_test("t3");
        chk("t3_err", {63'd0, err_overflow}, 64'd0);

        // Fifth B word in a frame is dropped and flags overflow
        send_b(32'h20);
        drive(1'b0, '0, 1'b1, 32'h24, 1'b0, 1'b0);
        chk("t4_err_set", {63'd0, err_overflow}, 64'd1);
        send_a(32'h10);
        end_test("t4");
        chk("t4_err_sticky", {63'd0, err_overflow}, 64'd1);

        // A pulse while draining B is dropped
        idle(1);
        do_reset();
        send_a(32'h10);
        idle(1);
        drive(1'b1, 32'h99, 1'b0, '0, 1'b0, 1'b0);
        chk("t5_err_a_drop", {63'd0, err_overflow}, 64'd1);
        send_b(32'h20);
        end_test("t5");

        // Two frames back-to-back, frame 2 B starting on frame 1 last-read cycle
        do_reset();
        fd0 = fd_cnt;
        send_b(32'h20);
        send_a(32'h10);
        idle(3);
        send_b(32'h30);
        send_a(32'h40);
        end_test("t6");
        chk("t6_frame_done_count", 64'(fd_cnt - fd0), 64'd2);
        chk("t6_err", {63'd0, err_overflow}, 64'd0);

        // Reset mid-frame, then a clean frame
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h50 + DW'(i), 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        do_reset();
        send_a(32'h10);
        send_b(32'h20);
        end_test("t7");
        chk("t7_err", {63'd0, err_overflow}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
